// File: rtl/reg_file_wb_pkg.sv
// Purpose: shared constants for the writeback register file and the pipeline stages.
// Contents: data width, register address width, link and zero register indices.
package reg_file_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_NREG   = 32;
  localparam int unsigned WB_ADDR_W = $clog2(WB_NREG);

  localparam logic [WB_ADDR_W-1:0] WB_LINK_REG = WB_ADDR_W'(31);
  localparam logic [WB_ADDR_W-1:0] WB_ZERO_REG = '0;

endpackage

// File: rtl/reg_file_wb_ld_scoreboard.sv
// Purpose: pending-load scoreboard. One bit per register marks a load in flight;
//   decode stalls on a pending operand unless this cycle's load writeback resolves it.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_iss_ld/i_iss_dst  load issued this cycle and its destination
//   i_clr/i_clr_dst     load writeback this cycle and its effective destination
//   i_rs_addr/i_rt_addr operand addresses being decoded
//   o_stall             operand pending, decode must hold
module reg_file_wb_ld_scoreboard
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned NREG = WB_NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_iss_ld,
  input  logic [WB_ADDR_W-1:0] i_iss_dst,
  input  logic                 i_clr,
  input  logic [WB_ADDR_W-1:0] i_clr_dst,
  input  logic [WB_ADDR_W-1:0] i_rs_addr,
  input  logic [WB_ADDR_W-1:0] i_rt_addr,
  output logic                 o_stall
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_d;
  logic            w_rs_byp;
  logic            w_rt_byp;

  always_comb begin
    w_pend_d = r_pend;
    if (i_clr) w_pend_d[i_clr_dst] = 1'b0;
    // Set after clear: a newer load owns the register over the retiring one.
    if (i_iss_ld && (i_iss_dst != WB_ZERO_REG)) w_pend_d[i_iss_dst] = 1'b1;
    w_pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_d;
  end

  // Load data arriving this cycle is bypassed, so the operand no longer needs to wait.
  assign w_rs_byp = i_clr && (i_clr_dst == i_rs_addr);
  assign w_rt_byp = i_clr && (i_clr_dst == i_rt_addr);
  assign o_stall  = (r_pend[i_rs_addr] && !w_rs_byp) || (r_pend[i_rt_addr] && !w_rt_byp);

endmodule

// File: rtl/reg_file_wb.sv
// Purpose: writeback-side register file. Commits the writeback word to a 32 x 32 array,
//   serves two combinational read ports with same-cycle bypass, and tracks pending loads.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   wb_en/wb_dst/wb_isLd/wb_isCall/wb_data  writeback request
//   rs_addr/rt_addr -> rs_data/rt_data       read ports (r0 reads 0)
//   iss_ld/iss_dst                load issue for the scoreboard
//   stall                         operand pending, decode must hold
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = WB_DATA_W,
  parameter int unsigned NREG     = WB_NREG,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_en,
  input  logic [WB_ADDR_W-1:0] wb_dst,
  input  logic                 wb_isLd,
  input  logic                 wb_isCall,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [WB_ADDR_W-1:0] rs_addr,
  input  logic [WB_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  input  logic                 iss_ld,
  input  logic [WB_ADDR_W-1:0] iss_dst,
  output logic                 stall
);

  localparam logic [WB_ADDR_W-1:0] LinkAddr = WB_ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]    r_regs [NREG];
  logic [WB_ADDR_W-1:0] w_wdst;
  logic                 w_wb;
  logic                 w_we;
  logic                 w_ld_clr;

  assign w_wdst   = wb_isCall ? LinkAddr : wb_dst;
  // Gated by rst_n so the bypass path cannot leak data while reset is held.
  assign w_wb     = wb_en && rst_n;
  assign w_we     = w_wb && (w_wdst != WB_ZERO_REG);
  assign w_ld_clr = w_wb && wb_isLd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[w_wdst] <= wb_data;
    end
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (w_we && (w_wdst == rs_addr)) rs_data = wb_data;
    if (rs_addr == WB_ZERO_REG)      rs_data = '0;
    rt_data = r_regs[rt_addr];
    if (w_we && (w_wdst == rt_addr)) rt_data = wb_data;
    if (rt_addr == WB_ZERO_REG)      rt_data = '0;
  end

  reg_file_wb_ld_scoreboard #(
    .NREG (NREG)
  ) u_ld_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_iss_ld  (iss_ld),
    .i_iss_dst (iss_dst),
    .i_clr     (w_ld_clr),
    .i_clr_dst (w_wdst),
    .i_rs_addr (rs_addr),
    .i_rt_addr (rt_addr),
    .o_stall   (stall)
  );

endmodule
